dual_axis_ctrl_sequencer: RTL and testbench

- Sequences the LQR position-control arithmetic for both plate axes (X and Y) through a single shared, pipelined multiplier.
- Each control tick snapshots desired and actual ball positions for both axes, then issues four products back-to-back. It forms the signed error term per axis and emits two servo angle commands with one valid strobe.
- Sits between the touch-panel position decoder and the servo PWM generators. It replaces two independent per-axis controllers, halving multiplier usage.

---
 rtl/dual_axis_ctrl_sequencer_if.sv | 24 ++
 rtl/dual_axis_ctrl_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_dual_axis_ctrl_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_axis_ctrl_sequencer_if.sv
// Position inputs and servo command outputs of the dual-axis LQR sequencer.
// The slave modport is the sequencer side; the master modport drives positions and ticks.
interface dual_axis_ctrl_sequencer_if;
  logic        ctrl_clock;
  logic [11:0] desired_x;
  logic [11:0] actual_x;
  logic [11:0] desired_y;
  logic [11:0] actual_y;
  logic [11:0] angle_x;
  logic [11:0] angle_y;
  logic        valid;
  logic        busy;
  logic        overrun;

  modport master (
    output ctrl_clock, desired_x, actual_x, desired_y, actual_y,
    input  angle_x, angle_y, valid, busy, overrun
  );

  modport slave (
    input  ctrl_clock, desired_x, actual_x, desired_y, actual_y,
    output angle_x, angle_y, valid, busy, overrun
  );
endinterface

// File: rtl/dual_axis_ctrl_sequencer.sv
// Runs the X and Y axis LQR position arithmetic through one shared pipelined multiplier
// and emits both servo angle commands together with a single valid strobe.
module dual_axis_ctrl_sequencer #(
  parameter logic [11:0]        K_POS        = 12'd326,
  parameter logic [11:0]        K_REF        = 12'd326,
  parameter int                 MULT_LAT     = 3,
  parameter logic signed [12:0] ANGLE_OFFSET = 13'sd0
) (
  input logic                          clock,
  input logic                          reset,
  dual_axis_ctrl_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;

  logic        ctrl_q_r;
  logic        start_s;
  logic [11:0] op_ax_r;
  logic [11:0] op_dx_r;
  logic [11:0] op_ay_r;
  logic [11:0] op_dy_r;
  logic [1:0]  issue_idx_r;

  logic        load_ops_s;
  logic        mul_vld_s;
  logic [11:0] mul_a_s;
  logic [11:0] mul_b_s;
  logic        out_update_s;

  logic [23:0] pipe_prod_r [MULT_LAT];
  logic        pipe_vld_r  [MULT_LAT];
  logic [1:0]  pipe_tag_r  [MULT_LAT];
  logic        tail_vld_s;
  logic [1:0]  tail_tag_s;
  logic [23:0] tail_prod_s;
  logic [23:0] p_r [4];

  logic [11:0] angle_x_s;
  logic [11:0] angle_y_s;
  logic [11:0] angle_x_r;
  logic [11:0] angle_y_r;
  logic        valid_r;
  logic        busy_r;
  logic        overrun_r;

  // Floor of (p_act - p_des) / 4096, re-centred on 2048 plus trim, saturated to 12 bits.
  // The sum is kept 16 bits wide so extreme gains and trims clamp instead of wrapping.
  function automatic logic [11:0] axis_angle(input logic [23:0] p_act, input logic [23:0] p_des);
    logic signed [24:0] diff;
    logic signed [12:0] scaled;
    logic signed [15:0] sum;
    diff   = $signed({1'b0, p_act}) - $signed({1'b0, p_des});
    scaled = $signed(diff[24:12]);
    sum    = $signed({{3{scaled[12]}}, scaled}) + 16'sd2048
           + $signed({{3{ANGLE_OFFSET[12]}}, ANGLE_OFFSET});
    if (sum < 16'sd0) begin
      return 12'd0;
    end else if (sum > 16'sd4095) begin
      return 12'd4095;
    end else begin
      return sum[11:0];
    end
  endfunction

  assign start_s     = bus.ctrl_clock & ~ctrl_q_r;
  assign tail_vld_s  = pipe_vld_r[MULT_LAT-1];
  assign tail_tag_s  = pipe_tag_r[MULT_LAT-1];
  assign tail_prod_s = pipe_prod_r[MULT_LAT-1];

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; DRAIN ends when the tagged product of the last issue leaves the pipe
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_s = ST_ISSUE;
        else         state_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (issue_idx_r == 2'd3) state_s = ST_DRAIN;
        else                     state_s = ST_ISSUE;
      end
      ST_DRAIN: begin
        if (tail_vld_s && (tail_tag_s == 2'd3)) state_s = ST_OUTPUT;
        else                                    state_s = ST_DRAIN;
      end
      ST_OUTPUT: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Output decode: operand selection per issue slot and the strobes for the datapath
  always_comb begin
    load_ops_s   = 1'b0;
    mul_vld_s    = 1'b0;
    mul_a_s      = 12'd0;
    mul_b_s      = 12'd0;
    out_update_s = 1'b0;
    case (state_r)
      ST_IDLE: load_ops_s = start_s;
      ST_ISSUE: begin
        mul_vld_s = 1'b1;
        case (issue_idx_r)
          2'd0:    begin mul_a_s = op_ax_r; mul_b_s = K_POS; end
          2'd1:    begin mul_a_s = op_dx_r; mul_b_s = K_REF; end
          2'd2:    begin mul_a_s = op_ay_r; mul_b_s = K_POS; end
          2'd3:    begin mul_a_s = op_dy_r; mul_b_s = K_REF; end
          default: begin mul_a_s = 12'd0;   mul_b_s = 12'd0; end
        endcase
      end
      ST_DRAIN:  out_update_s = 1'b0;
      ST_OUTPUT: out_update_s = 1'b1;
      default:   out_update_s = 1'b0;
    endcase
    angle_x_s = axis_angle(p_r[0], p_r[1]);
    angle_y_s = axis_angle(p_r[2], p_r[3]);
  end

  // Shared multiplier: product, valid and issue tag travel together through the stages
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MULT_LAT; i++) begin
        pipe_prod_r[i] <= 24'd0;
        pipe_vld_r[i]  <= 1'b0;
        pipe_tag_r[i]  <= 2'd0;
      end
    end else begin
      pipe_prod_r[0] <= {12'd0, mul_a_s} * {12'd0, mul_b_s};
      pipe_vld_r[0]  <= mul_vld_s;
      pipe_tag_r[0]  <= issue_idx_r;
      for (int i = 1; i < MULT_LAT; i++) begin
        pipe_prod_r[i] <= pipe_prod_r[i-1];
        pipe_vld_r[i]  <= pipe_vld_r[i-1];
        pipe_tag_r[i]  <= pipe_tag_r[i-1];
      end
    end
  end

  // Product capture into p0..p3 by tag
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        p_r[i] <= 24'd0;
      end
    end else if (tail_vld_s) begin
      p_r[tail_tag_s] <= tail_prod_s;
    end
  end

  // Tick edge detect, operand snapshot, issue counter and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q_r    <= 1'b0;
      op_ax_r     <= 12'd0;
      op_dx_r     <= 12'd0;
      op_ay_r     <= 12'd0;
      op_dy_r     <= 12'd0;
      issue_idx_r <= 2'd0;
      angle_x_r   <= 12'd2048;
      angle_y_r   <= 12'd2048;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      ctrl_q_r <= bus.ctrl_clock;
      if (load_ops_s) begin
        op_ax_r <= bus.actual_x;
        op_dx_r <= bus.desired_x;
        op_ay_r <= bus.actual_y;
        op_dy_r <= bus.desired_y;
      end
      if (state_r == ST_ISSUE) issue_idx_r <= issue_idx_r + 2'd1;
      else                     issue_idx_r <= 2'd0;
      if (load_ops_s)        busy_r <= 1'b1;
      else if (out_update_s) busy_r <= 1'b0;
      // busy is still set during OUTPUT, so a tick landing there is an overrun too
      if (start_s && busy_r) overrun_r <= 1'b1;
      valid_r <= out_update_s;
      if (out_update_s) begin
        angle_x_r <= angle_x_s;
        angle_y_r <= angle_y_s;
      end
    end
  end

  assign bus.angle_x = angle_x_r;
  assign bus.angle_y = angle_y_r;
  assign bus.valid   = valid_r;
  assign bus.busy    = busy_r;
  assign bus.overrun = overrun_r;

endmodule

// File: tb/tb_dual_axis_ctrl_sequencer.sv
// Scoreboard bench: two sequencers (default gains and a saturating gain/trim set) share one
// stimulus stream; a tick-level model predicts results, a negedge monitor checks every cycle.
module tb_dual_axis_ctrl_sequencer;
  localparam int L   = 3;
  localparam int KP0 = 326;
  localparam int KR0 = 326;
  localparam int OF0 = 0;
  localparam int KP1 = 1023;
  localparam int KR1 = 1023;
  localparam int OF1 = 1500;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_clock = 1'b0;
  logic [11:0] desired_x = 12'd0;
  logic [11:0] actual_x  = 12'd0;
  logic [11:0] desired_y = 12'd0;
  logic [11:0] actual_y  = 12'd0;

  always #5 clock = ~clock;

  dual_axis_ctrl_sequencer_if bus0();
  dual_axis_ctrl_sequencer_if bus1();

  assign bus0.ctrl_clock = ctrl_clock;
  assign bus0.desired_x  = desired_x;
  assign bus0.actual_x   = actual_x;
  assign bus0.desired_y  = desired_y;
  assign bus0.actual_y   = actual_y;
  assign bus1.ctrl_clock = ctrl_clock;
  assign bus1.desired_x  = desired_x;
  assign bus1.actual_x   = actual_x;
  assign bus1.desired_y  = desired_y;
  assign bus1.actual_y   = actual_y;

  dual_axis_ctrl_sequencer dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0.slave)
  );

  dual_axis_ctrl_sequencer #(
    .K_POS        (12'd1023),
    .K_REF        (12'd1023),
    .MULT_LAT     (3),
    .ANGLE_OFFSET (13'sd1500)
  ) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  typedef struct {
    int cyc;
    int ax0;
    int ay0;
    int ax1;
    int ay1;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   prev_ctrl = 1'b0;
  bit   acc_v = 1'b0;
  int   acc_e = 0;
  bit   ovr_m = 1'b0;
  bit   rst_edge = 1'b0;
  int   h0x = 2048, h0y = 2048, h1x = 2048, h1y = 2048;

  // Angle from the control law: floor((act*kp - des*kr)/4096) + 2048 + off, clamped.
  function automatic int ref_angle(input int act, input int des, input int kp, input int kr, input int off);
    longint d;
    longint q;
    d = longint'(act) * kp - longint'(des) * kr;
    q = d / 4096;
    if ((d % 4096 != 0) && (d < 0)) q = q - 1;
    q = q + 2048 + off;
    if (q < 0) return 0;
    if (q > 4095) return 4095;
    return int'(q);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: sees ticks at the clock edge and queues the expected result of each accepted one.
  initial begin
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
      if (reset) begin
        prev_ctrl = 1'b0;
        acc_v     = 1'b0;
        ovr_m     = 1'b0;
        rst_edge  = 1'b1;
        sbq.delete();
      end else begin
        rst_edge = 1'b0;
        if (ctrl_clock && !prev_ctrl) begin
          if (acc_v && (cyc <= acc_e + L + 5)) begin
            ovr_m = 1'b1;
          end else begin
            acc_v = 1'b1;
            acc_e = cyc;
            sbq.push_back('{cyc + L + 5,
              ref_angle(actual_x, desired_x, KP0, KR0, OF0),
              ref_angle(actual_y, desired_y, KP0, KR0, OF0),
              ref_angle(actual_x, desired_x, KP1, KR1, OF1),
              ref_angle(actual_y, desired_y, KP1, KR1, OF1)});
          end
        end
        prev_ctrl = ctrl_clock;
      end
    end
  end

  // Monitor: compares both DUTs against the model every cycle, away from the active edge.
  initial begin
    bit ev;
    bit eb;
    forever begin
      @(negedge clock);
      if (rst_edge) begin
        h0x = 2048; h0y = 2048; h1x = 2048; h1y = 2048;
      end
      while ((sbq.size() > 0) && (sbq[0].cyc < cyc)) void'(sbq.pop_front());
      ev = (sbq.size() > 0) && (sbq[0].cyc == cyc);
      eb = acc_v && (cyc >= acc_e) && (cyc <= acc_e + L + 4);
      if (ev) begin
        h0x = sbq[0].ax0; h0y = sbq[0].ay0;
        h1x = sbq[0].ax1; h1y = sbq[0].ay1;
        void'(sbq.pop_front());
      end
      if (cyc > 0) begin
        chk("valid",       int'(bus0.valid),   int'(ev));
        chk("valid_sat",   int'(bus1.valid),   int'(ev));
        chk("busy",        int'(bus0.busy),    int'(eb));
        chk("busy_sat",    int'(bus1.busy),    int'(eb));
        chk("overrun",     int'(bus0.overrun), int'(ovr_m));
        chk("overrun_sat", int'(bus1.overrun), int'(ovr_m));
        chk("angle_x",     int'(bus0.angle_x), h0x);
        chk("angle_y",     int'(bus0.angle_y), h0y);
        chk("angle_x_sat", int'(bus1.angle_x), h1x);
        chk("angle_y_sat", int'(bus1.angle_y), h1y);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_pos(input int ax, input int dx, input int ay, input int dy);
    actual_x  = 12'(ax);
    desired_x = 12'(dx);
    actual_y  = 12'(ay);
    desired_y = 12'(dy);
  endtask

  task automatic tick(input int w, input int gap);
    ctrl_clock = 1'b1;
    step(w);
    ctrl_clock = 1'b0;
    step(gap - w);
  endtask

  // Stimulus: directed cases from the control-law corners, then randomized ticks.
  initial begin
    int guard;
    int w;
    int gap;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(10);

    set_pos(2048, 2048, 2048, 2048);
    tick(1, 12);

    set_pos(3000, 1000, 0, 4095);
    ctrl_clock = 1'b1;
    step(1);
    ctrl_clock = 1'b0;
    set_pos(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
            int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
    step(11);

    set_pos(4095, 0, 0, 4095);
    tick(1, 12);

    set_pos(1234, 2345, 3456, 567);
    tick(20, 30);

    set_pos(100, 4000, 4000, 100);
    tick(1, 4);
    set_pos(0, 0, 0, 0);
    tick(1, 12);

    set_pos(3900, 200, 150, 3800);
    ctrl_clock = 1'b1;
    step(1);
    ctrl_clock = 1'b0;
    step(4);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(5);
    set_pos(2500, 1500, 1800, 2200);
    tick(1, 12);

    for (int k = 0; k < 40; k++) begin
      set_pos(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
              int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
      w = int'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) gap = int'($urandom_range(w + 1, 8));
      else                           gap = int'($urandom_range(10, 16));
      tick(w, gap);
    end

    guard = 0;
    while ((sbq.size() > 0) && (guard < 100)) begin
      step(1);
      guard++;
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sbq.size());
    end
    step(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
